// File: rtl/pfgen_stride_if.sv
// Load-observation and prefetch-op port bundle between the core, the
// stride prefetch generator and the prefetch engine.
interface pfgen_stride_if #(
  parameter int LADDR_W  = 39,
  parameter int SPTBR_W  = 38,
  parameter int DELTA_W  = 8,
  parameter int WEIGHT_W = 4
);
  logic                coretopfg_ld_valid;
  logic [LADDR_W-1:0]  coretopfg_ld_laddr;
  logic [SPTBR_W-1:0]  coretopfg_ld_sptbr;
  logic                pfgtopfe_op_valid;
  logic                pfgtopfe_op_retry;
  logic [DELTA_W-1:0]  pfgtopfe_op_d;
  logic [WEIGHT_W-1:0] pfgtopfe_op_w;
  logic [LADDR_W-1:0]  pfgtopfe_op_laddr;
  logic [SPTBR_W-1:0]  pfgtopfe_op_sptbr;
  logic [15:0]         pfg_drop_cnt;

  modport master (
    input  coretopfg_ld_valid, coretopfg_ld_laddr, coretopfg_ld_sptbr, pfgtopfe_op_retry,
    output pfgtopfe_op_valid, pfgtopfe_op_d, pfgtopfe_op_w, pfgtopfe_op_laddr,
           pfgtopfe_op_sptbr, pfg_drop_cnt
  );

  modport slave (
    output coretopfg_ld_valid, coretopfg_ld_laddr, coretopfg_ld_sptbr, pfgtopfe_op_retry,
    input  pfgtopfe_op_valid, pfgtopfe_op_d, pfgtopfe_op_w, pfgtopfe_op_laddr,
           pfgtopfe_op_sptbr, pfg_drop_cnt
  );
endinterface

// File: rtl/pfgen_stride.sv
// Stride prefetch generator: trains a small page-keyed stride table from
// committed loads and offers one prefetch op per confidently strided load.
module pfgen_stride #(
  parameter int LADDR_W   = 39,
  parameter int SPTBR_W   = 38,
  parameter int DELTA_W   = 8,
  parameter int WEIGHT_W  = 4,
  parameter int ENTRIES   = 4,
  parameter int LINE_BITS = 6,
  parameter int THRESH    = 2
) (
  input logic           clk,
  input logic           reset,
  pfgen_stride_if.master bus
);
  localparam int PAGE_W = LADDR_W - 12;
  localparam int LL_W   = 12 - LINE_BITS;
  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int D_MIN  = -(2 ** (DELTA_W - 1));
  localparam int D_MAX  = (2 ** (DELTA_W - 1)) - 1;
  localparam logic [WEIGHT_W-1:0] CONF_MAX  = '1;
  localparam logic [LADDR_W-1:0]  LINE_MASK = ~LADDR_W'((64'd1 << LINE_BITS) - 64'd1);

  logic [ENTRIES-1:0]        tab_valid;
  logic [PAGE_W-1:0]         tab_page  [ENTRIES];
  logic [LL_W-1:0]           tab_last  [ENTRIES];
  logic signed [DELTA_W-1:0] tab_delta [ENTRIES];
  logic [WEIGHT_W-1:0]       tab_conf  [ENTRIES];
  logic [SPTBR_W-1:0]        cur_sptbr;
  logic [IDX_W-1:0]          rr_ptr;

  logic                op_valid;
  logic [DELTA_W-1:0]  op_d;
  logic [WEIGHT_W-1:0] op_w;
  logic [LADDR_W-1:0]  op_laddr;
  logic [SPTBR_W-1:0]  op_sptbr;
  logic [15:0]         drop_cnt;

  logic [PAGE_W-1:0]         ld_page;
  logic [LL_W-1:0]           ld_line;
  logic                      hit, free, same_sp, nd_zero, nd_fits, nd_match;
  logic                      alloc, train, cand;
  logic [IDX_W-1:0]          hit_idx, free_idx, alloc_idx;
  logic signed [LL_W:0]      nd;
  int                        nd_int;
  logic signed [DELTA_W-1:0] nd_d;
  logic [WEIGHT_W-1:0]       conf_nx;

  assign ld_page = bus.coretopfg_ld_laddr[LADDR_W-1:12];
  assign ld_line = bus.coretopfg_ld_laddr[11:LINE_BITS];

  // Lowest-index free entry wins, so the descending loop overwrites upward.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (tab_valid[i] && tab_page[i] == ld_page) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!tab_valid[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign nd       = $signed({1'b0, ld_line}) - $signed({1'b0, tab_last[hit_idx]});
  assign nd_int   = int'(nd);
  assign nd_fits  = (nd_int >= D_MIN) && (nd_int <= D_MAX);
  assign nd_d     = DELTA_W'(nd_int);
  assign nd_zero  = (nd == '0);
  assign nd_match = nd_fits && (nd_d == tab_delta[hit_idx]);
  assign conf_nx  = (tab_conf[hit_idx] == CONF_MAX) ? CONF_MAX : tab_conf[hit_idx] + 1'b1;

  assign same_sp   = (bus.coretopfg_ld_sptbr == cur_sptbr);
  assign alloc     = bus.coretopfg_ld_valid && (!same_sp || !hit);
  assign train     = bus.coretopfg_ld_valid && same_sp && hit && !nd_zero;
  assign alloc_idx = !same_sp ? '0 : (free ? free_idx : rr_ptr);
  assign cand      = train && nd_match && (conf_nx >= WEIGHT_W'(THRESH));

  // NOTE: sequential state uses non-blocking assignments so every block sees
  // pre-edge values; the later tab_valid write below overrides the flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tab_valid <= '0;
      cur_sptbr <= '0;
      rr_ptr    <= '0;
    end else if (bus.coretopfg_ld_valid) begin
      if (!same_sp) begin
        tab_valid            <= '0;
        tab_valid[alloc_idx] <= 1'b1;
        cur_sptbr            <= bus.coretopfg_ld_sptbr;
      end else if (!hit) begin
        tab_valid[alloc_idx] <= 1'b1;
        if (!free) rr_ptr <= rr_ptr + 1'b1;
      end
    end
  end

  // NOTE: payload fields carry no reset; they are only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tab_page[alloc_idx]  <= ld_page;
      tab_last[alloc_idx]  <= ld_line;
      tab_delta[alloc_idx] <= '0;
      tab_conf[alloc_idx]  <= '0;
    end else if (train) begin
      tab_last[hit_idx] <= ld_line;
      if (nd_match) begin
        tab_conf[hit_idx] <= conf_nx;
      end else begin
        tab_delta[hit_idx] <= nd_fits ? nd_d : '0;
        tab_conf[hit_idx]  <= '0;
      end
    end
  end

  // Single-entry output register; a blocked candidate is counted, not queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_valid <= 1'b0;
      op_d     <= '0;
      op_w     <= '0;
      op_laddr <= '0;
      op_sptbr <= '0;
      drop_cnt <= '0;
    end else if (cand) begin
      if (!op_valid || !bus.pfgtopfe_op_retry) begin
        op_valid <= 1'b1;
        op_d     <= nd_d;
        op_w     <= conf_nx;
        op_laddr <= bus.coretopfg_ld_laddr & LINE_MASK;
        op_sptbr <= bus.coretopfg_ld_sptbr;
      end else if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end else if (op_valid && !bus.pfgtopfe_op_retry) begin
      op_valid <= 1'b0;
    end
  end

  assign bus.pfgtopfe_op_valid = op_valid;
  assign bus.pfgtopfe_op_d     = op_d;
  assign bus.pfgtopfe_op_w     = op_w;
  assign bus.pfgtopfe_op_laddr = op_laddr;
  assign bus.pfgtopfe_op_sptbr = op_sptbr;
  assign bus.pfg_drop_cnt      = drop_cnt;
endmodule

// File: tb/tb_pfgen_stride.sv
// Directed and randomized checks of pfgen_stride against a page/stride
// reference model built from plain integer arithmetic.
module tb_pfgen_stride;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pfgen_stride_if bus ();
  pfgen_stride dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          v;
    logic [26:0] page;
    int          line;
    int          delta;
    int          conf;
  } ent_t;

  ent_t        tab [4];
  logic [37:0] m_sp;
  int          m_rr;
  bit          m_valid;
  logic [7:0]  m_d;
  logic [3:0]  m_w;
  logic [38:0] m_laddr;
  logic [37:0] m_sptbr;
  int          m_drop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (tab[i]) tab[i] = '{1'b0, 27'd0, 0, 0, 0};
    m_sp = '0; m_rr = 0;
    m_valid = 1'b0; m_d = '0; m_w = '0; m_laddr = '0; m_sptbr = '0; m_drop = 0;
  endtask

  task automatic allocate(input logic [26:0] page, input int line);
    int idx = -1;
    for (int i = 3; i >= 0; i--) if (!tab[i].v) idx = i;
    if (idx < 0) begin
      idx  = m_rr;
      m_rr = (m_rr + 1) % 4;
    end
    tab[idx] = '{1'b1, page, line, 0, 0};
  endtask

  task automatic model_step(input bit v, input logic [38:0] a, input logic [37:0] s, input bit r);
    bit          cand = 1'b0;
    int          nd = 0;
    int          idx = -1;
    logic [26:0] page = a[38:12];
    int          line = int'(a[11:6]);
    if (v) begin
      if (s != m_sp) begin
        foreach (tab[i]) tab[i].v = 1'b0;
        m_sp = s;
        allocate(page, line);
      end else begin
        for (int i = 0; i < 4; i++) if (tab[i].v && tab[i].page == page) idx = i;
        if (idx < 0) allocate(page, line);
        else begin
          nd = line - tab[idx].line;
          if (nd != 0) begin
            if (nd == tab[idx].delta) begin
              if (tab[idx].conf < 15) tab[idx].conf++;
              cand = (tab[idx].conf >= 2);
            end else begin
              tab[idx].delta = nd;
              tab[idx].conf  = 0;
            end
            tab[idx].line = line;
          end
        end
      end
    end
    if (cand) begin
      if (!m_valid || !r) begin
        m_valid = 1'b1; m_d = 8'(nd); m_w = 4'(tab[idx].conf);
        m_laddr = {a[38:6], 6'b0}; m_sptbr = s;
      end else if (m_drop < 65535) m_drop++;
    end else if (m_valid && !r) m_valid = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 64'(bus.pfgtopfe_op_valid), 64'(m_valid));
    check({tag, ".d"},     64'(bus.pfgtopfe_op_d),     64'(m_d));
    check({tag, ".w"},     64'(bus.pfgtopfe_op_w),     64'(m_w));
    check({tag, ".laddr"}, 64'(bus.pfgtopfe_op_laddr), 64'(m_laddr));
    check({tag, ".sptbr"}, 64'(bus.pfgtopfe_op_sptbr), 64'(m_sptbr));
    check({tag, ".drop"},  64'(bus.pfg_drop_cnt),      64'(m_drop));
  endtask

  task automatic cycle(input bit v, input logic [38:0] a, input logic [37:0] s, input bit r);
    @(negedge clk);
    bus.coretopfg_ld_valid = v;
    bus.coretopfg_ld_laddr = a;
    bus.coretopfg_ld_sptbr = s;
    bus.pfgtopfe_op_retry  = r;
    model_step(v, a, s, r);
    @(posedge clk);
    #1;
    compare_all("model");
  endtask

  task automatic expect_op(input string tag, input logic [7:0] d, input logic [3:0] w,
                           input logic [38:0] la, input logic [37:0] sp);
    check({tag, ".valid"}, 64'(bus.pfgtopfe_op_valid), 64'd1);
    check({tag, ".d"},     64'(bus.pfgtopfe_op_d),     64'(d));
    check({tag, ".w"},     64'(bus.pfgtopfe_op_w),     64'(w));
    check({tag, ".laddr"}, 64'(bus.pfgtopfe_op_laddr), 64'(la));
    check({tag, ".sptbr"}, 64'(bus.pfgtopfe_op_sptbr), 64'(sp));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".valid"}, 64'(bus.pfgtopfe_op_valid), 64'd0);
  endtask

  int          pl [5];
  int          ps [5];
  logic [26:0] pg [5];

  initial begin
    reset = 1'b1;
    bus.coretopfg_ld_valid = 1'b0;
    bus.coretopfg_ld_laddr = '0;
    bus.coretopfg_ld_sptbr = '0;
    bus.pfgtopfe_op_retry  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    compare_all("reset");
    check("reset.rr_ptr", 64'(dut.rr_ptr), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: ascending stride, op on the fourth load, valid for one cycle
    cycle(1, 39'h1000, 38'd5, 0); expect_idle("t1.l1");
    cycle(1, 39'h1040, 38'd5, 0); expect_idle("t1.l2");
    cycle(1, 39'h1080, 38'd5, 0); expect_idle("t1.l3");
    cycle(1, 39'h10C0, 38'd5, 0); expect_op("t1.op", 8'h01, 4'd2, 39'h10C0, 38'd5);
    cycle(0, 39'h0, 38'd5, 0);    expect_idle("t1.xfer");

    // 2: held under retry, second candidate dropped
    cycle(1, 39'h1100, 38'd5, 1); expect_op("t2.op", 8'h01, 4'd3, 39'h1100, 38'd5);
    cycle(1, 39'h1140, 38'd5, 1); expect_op("t2.hold", 8'h01, 4'd3, 39'h1100, 38'd5);
    check("t2.drop", 64'(bus.pfg_drop_cnt), 64'd1);
    cycle(0, 39'h0, 38'd5, 1);    expect_op("t2.hold2", 8'h01, 4'd3, 39'h1100, 38'd5);
    cycle(0, 39'h0, 38'd5, 0);    expect_idle("t2.xfer");

    // 3: descending stride, then same-line loads
    cycle(1, 39'h2FC0, 38'd5, 0);
    cycle(1, 39'h2F80, 38'd5, 0);
    cycle(1, 39'h2F40, 38'd5, 0); expect_idle("t3.l3");
    cycle(1, 39'h2F00, 38'd5, 0); expect_op("t3.op", 8'hFF, 4'd2, 39'h2F00, 38'd5);
    cycle(1, 39'h2F00, 38'd5, 0); expect_idle("t3.same1");
    cycle(1, 39'h2F08, 38'd5, 0); expect_idle("t3.same2");

    // 4: retrain page 0x1000, sptbr change flushes but keeps the held op
    cycle(1, 39'h1000, 38'd5, 0);
    cycle(1, 39'h1040, 38'd5, 0);
    cycle(1, 39'h1080, 38'd5, 0);
    cycle(1, 39'h10C0, 38'd5, 0); expect_op("t4.op", 8'h01, 4'd2, 39'h10C0, 38'd5);
    cycle(1, 39'h1100, 38'd6, 1); expect_op("t4.flush_hold", 8'h01, 4'd2, 39'h10C0, 38'd5);
    cycle(1, 39'h1140, 38'd6, 0); expect_idle("t4.after_flush");

    // 5: five pages evict the first; victims are entries 0 then 1
    cycle(1, 39'h3000, 38'd6, 0);
    cycle(1, 39'h4000, 38'd6, 0);
    cycle(1, 39'h5000, 38'd6, 0);
    cycle(1, 39'h6000, 38'd6, 0);
    check("t5.rr_after_victim0", 64'(dut.rr_ptr), 64'd1);
    cycle(1, 39'h1180, 38'd6, 0); expect_idle("t5.realloc");
    check("t5.rr_after_victim1", 64'(dut.rr_ptr), 64'd2);
    cycle(1, 39'h11C0, 38'd6, 0); expect_idle("t5.conf0");
    cycle(1, 39'h1200, 38'd6, 0); expect_idle("t5.conf1");
    cycle(1, 39'h1240, 38'd6, 0); expect_op("t5.op", 8'h01, 4'd2, 39'h1240, 38'd6);

    // 6: reset while an op is held under retry
    cycle(1, 39'h1280, 38'd6, 1);
    check("t6.drop_before", 64'(bus.pfg_drop_cnt), 64'd2);
    @(negedge clk);
    reset = 1'b1;
    bus.coretopfg_ld_valid = 1'b0;
    #1;
    model_reset();
    compare_all("t6.async");
    check("t6.valid", 64'(bus.pfgtopfe_op_valid), 64'd0);
    check("t6.drop",  64'(bus.pfg_drop_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle(1, 39'h7000, 38'd6, 0);
    cycle(1, 39'h7040, 38'd6, 0);
    cycle(1, 39'h7080, 38'd6, 0); expect_idle("t6.l3");
    cycle(1, 39'h70C0, 38'd6, 0); expect_op("t6.op", 8'h01, 4'd2, 39'h70C0, 38'd6);

    // Randomized strided traffic with occasional noise, retry and sptbr flips
    pg = '{27'h8, 27'h9, 27'hA, 27'hB, 27'h8F};
    ps = '{1, 2, -1, -3, 1};
    foreach (pl[i]) pl[i] = int'($urandom_range(0, 63));
    for (int n = 0; n < 600; n++) begin
      int          p  = int'($urandom_range(0, 4));
      bit          v  = ($urandom_range(0, 3) != 0);
      logic [37:0] sp = ($urandom_range(0, 40) == 0) ? 38'd7 : 38'd6;
      bit          r  = ($urandom_range(0, 2) == 0);
      logic [38:0] a;
      if ($urandom_range(0, 7) == 0) pl[p] = int'($urandom_range(0, 63));
      else pl[p] = (pl[p] + ps[p]) & 63;
      a = (39'(pg[p]) << 12) | (39'(pl[p]) << 6) | 39'($urandom_range(0, 63));
      cycle(v, a, sp, r);
    end
    repeat (3) cycle(0, 39'h0, 38'd6, 0);
    expect_idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
